// File: rtl/cursor_ctrl_if.sv
// Beam, control and overlay bundle between the pixel pipeline
// and the cursor controller.
interface cursor_ctrl_if #(
  parameter int POS_W = 16
);
  logic [1:0]       sw;
  logic             btn;
  logic             v_sync;
  logic [POS_W-1:0] sx;
  logic [POS_W-1:0] sy;
  logic             frame_tick;
  logic [POS_W-1:0] sprite_x;
  logic [POS_W-1:0] sprite_y;
  logic [3:0]       speed;
  logic             sprite_hit;
  logic [7:0]       sprite_red;
  logic [7:0]       sprite_green;
  logic [7:0]       sprite_blue;

  modport master (
    output sw, btn, v_sync, sx, sy,
    input  frame_tick, sprite_x, sprite_y, speed,
    input  sprite_hit, sprite_red, sprite_green, sprite_blue
  );

  modport slave (
    input  sw, btn, v_sync, sx, sy,
    output frame_tick, sprite_x, sprite_y, speed,
    output sprite_hit, sprite_red, sprite_green, sprite_blue
  );
endinterface

// File: rtl/cursor_ctrl.sv
// Frame-stepped cursor with hold-to-accelerate speed, screen
// clamping and a registered overlay for the pixel mixer.
module cursor_ctrl #(
  parameter int          POS_W        = 16,
  parameter int          SCREEN_W     = 800,
  parameter int          SCREEN_H     = 600,
  parameter int          SPRITE_W     = 16,
  parameter int          SPRITE_H     = 16,
  parameter int          INIT_X       = 392,
  parameter int          INIT_Y       = 292,
  parameter int          MAX_SPEED    = 8,
  parameter int          ACCEL_FRAMES = 8,
  parameter int          SHAPE        = 0,
  parameter logic [23:0] COLOR        = 24'hFF0000
) (
  input logic        CLK,
  input logic        RESET,
  cursor_ctrl_if.slave bus
);

  localparam int HOLD_W =
    (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam int X_LIM = SCREEN_W - SPRITE_W;
  localparam int Y_LIM = SCREEN_H - SPRITE_H;

  localparam logic [POS_W:0] X_MAX = X_LIM[POS_W:0];
  localparam logic [POS_W:0] Y_MAX = Y_LIM[POS_W:0];
  localparam logic [POS_W:0] SPR_W = SPRITE_W[POS_W:0];
  localparam logic [POS_W:0] SPR_H = SPRITE_H[POS_W:0];

  localparam int HW = SPRITE_W / 2;
  localparam int HH = SPRITE_H / 2;

  localparam logic [POS_W-1:0] HALF_W = HW[POS_W-1:0];
  localparam logic [POS_W-1:0] HALF_H = HH[POS_W-1:0];
  localparam logic [POS_W-1:0] X0 = INIT_X[POS_W-1:0];
  localparam logic [POS_W-1:0] Y0 = INIT_Y[POS_W-1:0];

  localparam logic [3:0] SPD_MAX = MAX_SPEED[3:0];
  localparam int         HOLD_L  = ACCEL_FRAMES - 1;
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_L[HOLD_W-1:0];

  localparam logic [1:0] LEFT  = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] UP    = 2'b10;
  localparam logic [1:0] DOWN  = 2'b11;

  typedef enum logic {
    IDLE,
    MOVE
  } state_t;

  logic       vs_q1, vs_q2, vs_q3;
  logic       btn_q1, btn_s;
  logic [1:0] sw_q1, sw_s;
  logic       tick_q;

  state_t state_q, state_d;

  logic [1:0]        dir_q, dir_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_nx;
  logic [3:0]        speed_q, speed_d, step;
  logic              do_move;

  logic [POS_W-1:0] x_q, y_q, x_d, y_d;
  logic [POS_W:0]   xw, yw, stw;
  logic [POS_W:0]   x_dec, x_inc, y_dec, y_inc;
  logic [POS_W:0]   x_sum, y_sum;

  logic [POS_W:0]   sxw, syw, px, py;
  logic [POS_W-1:0] lx, ly;
  logic             in_x, in_y, on_cross, hit_d;

  logic       hit_q;
  logic [7:0] red_q, green_q, blue_q;

  // v_sync, btn and sw are all asynchronous to the pixel clock
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vs_q1  <= 1'b0;
      vs_q2  <= 1'b0;
      vs_q3  <= 1'b0;
      btn_q1 <= 1'b0;
      btn_s  <= 1'b0;
      sw_q1  <= 2'b00;
      sw_s   <= 2'b00;
      tick_q <= 1'b0;
    end else begin
      vs_q1  <= bus.v_sync;
      vs_q2  <= vs_q1;
      vs_q3  <= vs_q2;
      btn_q1 <= bus.btn;
      btn_s  <= btn_q1;
      sw_q1  <= bus.sw;
      sw_s   <= sw_q1;
      tick_q <= vs_q2 & ~vs_q3;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else if (tick_q) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = btn_s ? MOVE : IDLE;
      MOVE:    state_d = btn_s ? MOVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The entry tick counts as the first held frame, so speed
  // steps up every ACCEL_FRAMES moves in one direction.
  always_comb begin
    dir_d   = dir_q;
    hold_d  = hold_q;
    speed_d = speed_q;
    step    = 4'd1;
    do_move = 1'b0;
    hold_nx = (hold_q == HOLD_TOP) ? '0 : hold_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        speed_d = 4'd1;
        hold_d  = '0;
        if (btn_s) begin
          dir_d   = sw_s;
          do_move = 1'b1;
        end
      end
      MOVE: begin
        if (!btn_s) begin
          speed_d = 4'd1;
          hold_d  = '0;
        end else if (sw_s != dir_q) begin
          dir_d   = sw_s;
          speed_d = 4'd1;
          hold_d  = '0;
          do_move = 1'b1;
        end else begin
          step    = speed_q;
          do_move = 1'b1;
          hold_d  = hold_nx;
          if (hold_nx == HOLD_TOP) begin
            speed_d = (speed_q >= SPD_MAX) ?
                      SPD_MAX : speed_q + 4'd1;
          end
        end
      end
      default: begin
        speed_d = 4'd1;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    xw    = {1'b0, x_q};
    yw    = {1'b0, y_q};
    stw   = {{(POS_W-3){1'b0}}, step};
    x_sum = xw + stw;
    y_sum = yw + stw;
    x_dec = (xw >= stw) ? xw - stw : '0;
    y_dec = (yw >= stw) ? yw - stw : '0;
    x_inc = (x_sum > X_MAX) ? X_MAX : x_sum;
    y_inc = (y_sum > Y_MAX) ? Y_MAX : y_sum;
    x_d   = x_q;
    y_d   = y_q;
    if (do_move) begin
      unique case (1'b1)
        dir_d == LEFT:  x_d = x_dec[POS_W-1:0];
        dir_d == RIGHT: x_d = x_inc[POS_W-1:0];
        dir_d == UP:    y_d = y_dec[POS_W-1:0];
        dir_d == DOWN:  y_d = y_inc[POS_W-1:0];
        default:        x_d = x_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dir_q   <= LEFT;
      hold_q  <= '0;
      speed_q <= 4'd1;
      x_q     <= X0;
      y_q     <= Y0;
    end else if (tick_q) begin
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      speed_q <= speed_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    sxw      = {1'b0, bus.sx};
    syw      = {1'b0, bus.sy};
    px       = {1'b0, x_q};
    py       = {1'b0, y_q};
    lx       = bus.sx - x_q;
    ly       = bus.sy - y_q;
    in_x     = (sxw >= px) && (sxw < px + SPR_W);
    in_y     = (syw >= py) && (syw < py + SPR_H);
    on_cross = (lx == HALF_W) || (ly == HALF_H);
    hit_d    = in_x && in_y && ((SHAPE == 0) || on_cross);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_q   <= 1'b0;
      red_q   <= 8'h00;
      green_q <= 8'h00;
      blue_q  <= 8'h00;
    end else begin
      hit_q   <= hit_d;
      red_q   <= hit_d ? COLOR[23:16] : 8'h00;
      green_q <= hit_d ? COLOR[15:8]  : 8'h00;
      blue_q  <= hit_d ? COLOR[7:0]   : 8'h00;
    end
  end

  assign bus.frame_tick   = tick_q;
  assign bus.sprite_x     = x_q;
  assign bus.sprite_y     = y_q;
  assign bus.speed        = speed_q;
  assign bus.sprite_hit   = hit_q;
  assign bus.sprite_red   = red_q;
  assign bus.sprite_green = green_q;
  assign bus.sprite_blue  = blue_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: tick timing, acceleration,
// clamping, reset and box/crosshair overlay.
module tb_cursor_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  cursor_ctrl_if #(.POS_W(16)) ia ();
  cursor_ctrl_if #(.POS_W(16)) ib ();
  cursor_ctrl_if #(.POS_W(16)) ic ();

  cursor_ctrl u_a (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ia)
  );

  cursor_ctrl #(
    .SHAPE  (1),
    .INIT_X (100),
    .INIT_Y (100)
  ) u_b (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ib)
  );

  cursor_ctrl #(
    .INIT_X (83),
    .INIT_Y (532)
  ) u_c (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ic)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk);
    ia.v_sync = 1'b1;
    ic.v_sync = 1'b1;
    repeat (5) @(negedge clk);
    ia.v_sync = 1'b0;
    ic.v_sync = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  int hx [11] = '{108, 108, 108, 100, 115, 116,  99, 100, 109, 108, 108};
  int hy [11] = '{100, 115, 116, 108, 108, 108, 108, 100, 109,  99, 108};
  int he [11] = '{  1,   1,   0,   1,   1,   0,   0,   0,   0,   0,   1};

  int cx [4] = '{0, 15, 16, 5};
  int cy [4] = '{584, 599, 590, 583};
  int ce [4] = '{1, 1, 0, 0};

  logic [4:0] seen;
  logic       any;

  initial begin
    rst       = 1'b1;
    ia.sw     = 2'b00;
    ia.btn    = 1'b0;
    ia.v_sync = 1'b0;
    ia.sx     = '0;
    ia.sy     = '0;
    ib.sw     = 2'b00;
    ib.btn    = 1'b0;
    ib.v_sync = 1'b0;
    ib.sx     = '0;
    ib.sy     = '0;
    ic.sw     = 2'b00;
    ic.btn    = 1'b0;
    ic.v_sync = 1'b0;
    ic.sx     = '0;
    ic.sy     = '0;
    repeat (3) @(negedge clk);

    check("rst_x", 32'(ia.sprite_x), 392);
    check("rst_y", 32'(ia.sprite_y), 292);
    check("rst_spd", 32'(ia.speed), 1);
    check("rst_tick", 32'(ia.frame_tick), 0);
    check("rst_hit", 32'(ia.sprite_hit), 0);
    check("rst_red", 32'(ia.sprite_red), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ib.sx = 16'(hx[i]);
      ib.sy = 16'(hy[i]);
      #1;
      check("x_lat", 32'(ib.sprite_hit), (i == 0) ? 0 : he[i-1]);
      @(negedge clk);
      check("x_hit", 32'(ib.sprite_hit), he[i]);
      check("x_red", 32'(ib.sprite_red), he[i] ? 32'hFF : 0);
      check("x_grn", 32'(ib.sprite_green), 0);
    end

    @(negedge clk);
    ia.v_sync = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      seen[i] = ia.frame_tick;
    end
    check("tick_rise", 32'(seen), 32'b00100);
    @(negedge clk);
    ia.v_sync = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      any = any | ia.frame_tick;
    end
    check("tick_fall", 32'(any), 0);
    check("idle_x", 32'(ia.sprite_x), 392);

    ia.btn = 1'b1;
    ia.sw  = 2'b01;
    frames(8);
    check("acc8_x", 32'(ia.sprite_x), 400);
    check("acc8_spd", 32'(ia.speed), 2);
    frames(8);
    check("acc16_x", 32'(ia.sprite_x), 416);
    check("acc16_spd", 32'(ia.speed), 3);
    frames(4);
    check("acc20_x", 32'(ia.sprite_x), 428);
    check("acc20_y", 32'(ia.sprite_y), 292);
    check("acc20_spd", 32'(ia.speed), 3);

    ia.sw = 2'b10;
    frames(1);
    check("turn_x", 32'(ia.sprite_x), 428);
    check("turn_y", 32'(ia.sprite_y), 291);
    check("turn_spd", 32'(ia.speed), 1);

    @(negedge clk);
    ia.sx = 16'd430;
    ia.sy = 16'd295;
    @(negedge clk);
    check("pre_hit", 32'(ia.sprite_hit), 1);
    check("pre_red", 32'(ia.sprite_red), 32'hFF);
    #2 rst = 1'b1;
    #1;
    check("mid_x", 32'(ia.sprite_x), 392);
    check("mid_y", 32'(ia.sprite_y), 292);
    check("mid_spd", 32'(ia.speed), 1);
    check("mid_hit", 32'(ia.sprite_hit), 0);
    check("mid_red", 32'(ia.sprite_red), 0);
    @(negedge clk);
    rst = 1'b0;
    frames(1);
    check("post_x", 32'(ia.sprite_x), 392);
    check("post_y", 32'(ia.sprite_y), 291);
    check("post_spd", 32'(ia.speed), 1);

    ia.btn = 1'b0;
    frames(1);
    check("rel_y", 32'(ia.sprite_y), 291);
    check("rel_spd", 32'(ia.speed), 1);

    ic.btn = 1'b1;
    ic.sw  = 2'b11;
    frames(24);
    check("dn24_y", 32'(ic.sprite_y), 580);
    check("dn24_spd", 32'(ic.speed), 4);
    frames(1);
    check("dn_clamp", 32'(ic.sprite_y), 584);
    frames(1);
    check("dn_stay", 32'(ic.sprite_y), 584);
    check("dn_spd", 32'(ic.speed), 4);

    ic.sw = 2'b00;
    frames(32);
    check("lf32_x", 32'(ic.sprite_x), 3);
    check("lf32_spd", 32'(ic.speed), 5);
    frames(1);
    check("lf_clamp", 32'(ic.sprite_x), 0);
    frames(1);
    check("lf_stay", 32'(ic.sprite_x), 0);
    check("lf_spd", 32'(ic.speed), 5);
    check("lf_y", 32'(ic.sprite_y), 584);

    ic.btn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ic.sx = 16'(cx[i]);
      ic.sy = 16'(cy[i]);
      @(negedge clk);
      check("box_hit", 32'(ic.sprite_hit), ce[i]);
      check("box_red", 32'(ic.sprite_red), ce[i] ? 32'hFF : 0);
      check("box_blu", 32'(ic.sprite_blue), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cursor_ctrl.md
Name: cursor_ctrl

Overview:
Parametrised successor to the frame-stepped sprite pointer. It runs on the pixel clock and derives a one-cycle frame tick from a synchronised v_sync rising edge. It moves a rectangular or crosshair cursor with hold-to-accelerate speed, clamps it to the screen, and emits registered overlay colour and hit signals for the pixel mixer. Downstream, the viewport logic consumes sprite_x and sprite_y as the zoom centre.

Parameters:
POS_W, 16, width of sprite_x, sprite_y, sx and sy.
SCREEN_W, 800, active pixels per line.
SCREEN_H, 600, active lines per frame.
SPRITE_W, 16, cursor width in pixels.
SPRITE_H, 16, cursor height in pixels.
INIT_X, 392, reset x position, default (SCREEN_W-SPRITE_W)/2.
INIT_Y, 292, reset y position, default (SCREEN_H-SPRITE_H)/2.
MAX_SPEED, 8, maximum pixels moved per frame, ≥1.
ACCEL_FRAMES, 8, held frames per speed increment, ≥1.
SHAPE, 0, cursor shape: 0 = solid box, 1 = crosshair (centre row and centre column only).
COLOR, 24'hFF0000, overlay RGB colour.

Ports:
CLK  in  1  pixel clock
RESET  in  1  asynchronous reset, active-high
sw  in  2  direction select: 00 left, 01 right, 10 up, 11 down
btn  in  1  move request, asynchronous
sx  in  POS_W  current beam x position
sy  in  POS_W  current beam y position
v_sync  in  1  vertical sync, asynchronous to CLK
frame_tick  out  1  one-cycle pulse per frame
sprite_x  out  POS_W  cursor left edge
sprite_y  out  POS_W  cursor top edge
speed  out  4  current step size, 1..MAX_SPEED
sprite_hit  out  1  registered: beam pixel lies on the cursor
sprite_red  out  8  overlay colour, red channel
sprite_green  out  8  overlay colour, green channel
sprite_blue  out  8  overlay colour, blue channel

Behaviour:
- RESET is asynchronous and active-high. While RESET is asserted:
  - all synchroniser flops = 0; frame_tick = 0; state = IDLE
  - sprite_x = INIT_X, sprite_y = INIT_Y, speed = 1, hold_cnt = 0
  - sprite_hit = 0; all colour outputs = 0
  - RESET overrides every other event, including a coincident tick.
- Synchronisers:
  - v_sync, btn and sw each pass through 2 flops.
  - A third v_sync flop supports edge detection.
  - frame_tick is registered: it is high for exactly 1 cycle, 3 CLK edges after v_sync is first sampled high.
  - One tick per v_sync rising edge; no tick on a falling edge.
- State, position and speed change only in the cycle frame_tick = 1. They are held at all other times.
- FSM, evaluated on each tick using the synchronised btn_s and sw_s:
  - IDLE, btn_s = 0: stay in IDLE; speed = 1.
  - IDLE, btn_s = 1: go to MOVE; dir_q = sw_s; move by 1; hold_cnt = 0; speed = 1.
  - MOVE, btn_s = 0: go to IDLE; no move; speed = 1; hold_cnt = 0.
  - MOVE, btn_s = 1, sw_s ≠ dir_q: stay in MOVE; dir_q = sw_s; speed = 1; hold_cnt = 0; move 1 in the new direction on this same tick.
  - MOVE, btn_s = 1, sw_s = dir_q:
    - hold_cnt increments.
    - When hold_cnt reaches ACCEL_FRAMES-1: hold_cnt wraps to 0 and speed = min(speed+1, MAX_SPEED).
    - The move on this tick uses the speed value from before the update.
- Move arithmetic is done at POS_W+1 bits; no wrap-around.
  - left: x = (x ≥ speed) ? x-speed : 0
  - right: x = min(x+speed, SCREEN_W-SPRITE_W)
  - up and down: same rules on y, with limit SCREEN_H-SPRITE_H
  - A cursor already at a limit stays put; FSM and speed still update.
- Hit and colour, 1-cycle latency, registered every CLK:
  - Local coordinates: lx = sx - sprite_x, ly = sy - sprite_y.
  - Box hit: sx ≥ sprite_x and sx < sprite_x+SPRITE_W and sy ≥ sprite_y and sy < sprite_y+SPRITE_H.
  - Crosshair hit: box hit and (lx == SPRITE_W/2 or ly == SPRITE_H/2).
  - Colour outputs = COLOR when the registered hit = 1, else 0. Outputs are never X.
- Glitch-free by construction: position changes only on the tick, which falls in vertical blanking.

Test Plan:
- Assert RESET mid-move with btn held → sprite_x = 392, sprite_y = 292, speed = 1, hit and colour = 0 within the same cycle. After release, first tick moves by 1.
- Hold btn with sw = 01 for 20 ticks, ACCEL_FRAMES = 8 → speed rises 1→2 after 8 ticks and 2→3 after 16 ticks. sprite_x = 392+8×1+8×2+4×3 = 428.
- sprite_x = 3, speed = 5, move left → sprite_x = 0. Next tick stays at 0.
- sprite_y = 580, speed = 4, move down → sprite_y = 584.
- Change sw from 01 to 10 while btn is held at speed 3 → on that tick sprite_y decrements by 1, sprite_x is unchanged, speed = 1.
- SHAPE = 1, cursor at (100,100), sweep sx,sy → sprite_hit high only at sx = 108 or sy = 108 inside the box, 1 cycle after the beam. Red = FF on hits, 00 elsewhere.
- Toggle v_sync 1→0 → no frame_tick. Toggle v_sync 0→1 → exactly one frame_tick, 3 cycles later.
